ad7864_reader: RTL

Read-side sequencer for the AD7864 four-channel ADC, the counterpart to the conversion driver that issues CONVST and the ADC clock. The block watches the DSP conversion strobe and the ADC BUSY line. When a conversion finishes it runs the CS/RD read cycle for every enabled channel and latches the 12-bit results into an output frame. It then signals the DSP with a ready/ack handshake and flags overrun and timeout errors.

---
 rtl/ad7864_reader_if.sv | 28 ++
 rtl/ad7864_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ad7864_reader_if.sv
// Pin bundle between the AD7864 read sequencer, the ADC and the DSP.
// slave = the reader block; master = the ADC/DSP side driving it.
interface ad7864_reader_if #(
  parameter int NCH = 4,
  parameter int DW  = 12
);
  logic              conv_bar;
  logic              ad_busy;
  logic [DW-1:0]     ad_db;
  logic              ad_cs_bar;
  logic              ad_rd_bar;
  logic [NCH*DW-1:0] ch_data;
  logic              frame_rdy;
  logic              frame_ack;
  logic              overrun;
  logic              timeout;
  logic              err_clr;

  modport slave (
    input  conv_bar, ad_busy, ad_db, frame_ack, err_clr,
    output ad_cs_bar, ad_rd_bar, ch_data, frame_rdy, overrun, timeout
  );

  modport master (
    output conv_bar, ad_busy, ad_db, frame_ack, err_clr,
    input  ad_cs_bar, ad_rd_bar, ch_data, frame_rdy, overrun, timeout
  );
endinterface

// File: rtl/ad7864_reader.sv
// AD7864 read-side sequencer: waits for BUSY to fall, runs CS/RD per channel, latches a frame.
// Define AD7864_RD_TIMEOUT_EN to build the WAIT_BUSY watchdog and the timeout flag.
module ad7864_reader #(
  parameter int NCH     = 4,
  parameter int DW      = 12,
  parameter int RD_LOW  = 3,
  parameter int RD_HIGH = 2,
  parameter int TIMEOUT = 255
) (
  input  logic           clkin,
  input  logic           rst_bar,
  ad7864_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_BUSY, READ_LO, READ_HI, DONE} state_t;

  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RDMAX = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
  localparam int RCW   = $clog2(RDMAX + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  if (NCH < 1 || NCH > 4 || RD_LOW < 1 || RD_HIGH < 1 || TIMEOUT < 1 || TIMEOUT > 255)
  begin : g_bad_param
    $error("ad7864_reader: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [RCW-1:0]         cnt_q, cnt_d;
  logic [CHW-1:0]         chan_q, chan_d;
  logic [NCH-1:0][DW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][DW-1:0] frame_q, frame_d;
  logic                   cs_q, cs_d, rd_q, rd_d;
  logic                   rdy_q, rdy_d, ovr_q, ovr_d;

  logic conv_s1_q, conv_s2_q, conv_d1_q, conv_fall_q;
  logic busy_s1_q, busy_s2_q, busy_d1_q, busy_fall_q;
  logic lo_done, hi_done, tmo_hit;

  // Both strobes are asynchronous to clkin; the falling-edge pulse is registered so
  // BUSY pin -> CS/RD low is a fixed four edges.
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      conv_s1_q   <= 1'b1;
      conv_s2_q   <= 1'b1;
      conv_d1_q   <= 1'b1;
      conv_fall_q <= 1'b0;
      busy_s1_q   <= 1'b0;
      busy_s2_q   <= 1'b0;
      busy_d1_q   <= 1'b0;
      busy_fall_q <= 1'b0;
    end else begin
      conv_s1_q   <= bus.conv_bar;
      conv_s2_q   <= conv_s1_q;
      conv_d1_q   <= conv_s2_q;
      conv_fall_q <= conv_d1_q & ~conv_s2_q;
      busy_s1_q   <= bus.ad_busy;
      busy_s2_q   <= busy_s1_q;
      busy_d1_q   <= busy_s2_q;
      busy_fall_q <= busy_d1_q & ~busy_s2_q;
    end
  end

  assign lo_done = (state_q == READ_LO) && (cnt_q == RCW'(RD_LOW - 1));
  assign hi_done = (state_q == READ_HI) && (cnt_q == RCW'(RD_HIGH - 1));

`ifdef AD7864_RD_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_q, tmo_d;

  assign tmo_hit = (state_q == WAIT_BUSY) && (tmo_cnt_q == 8'(TIMEOUT));

  // Counter is held at zero in IDLE so it starts clean on entry to WAIT_BUSY.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE)
      tmo_cnt_d = '0;
    else if (state_q == WAIT_BUSY && tmo_cnt_q != 8'(TIMEOUT))
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    tmo_d = tmo_q;
    if (bus.err_clr) tmo_d = 1'b0;
    if (tmo_hit && !busy_fall_q) tmo_d = 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a BUSY fall beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (conv_fall_q) state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy_fall_q) state_d = READ_LO;
                 else if (tmo_hit) state_d = IDLE;
      READ_LO:   if (lo_done) state_d = (chan_q == LAST_CH) ? DONE : READ_HI;
      READ_HI:   if (hi_done) state_d = READ_LO;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output/datapath logic. CS/RD are decoded from the next state so the registered
  // pins line up exactly with the READ_LO/READ_HI states.
  always_comb begin
    cs_d     = !(state_d == READ_LO || state_d == READ_HI);
    rd_d     = !(state_d == READ_LO);
    cnt_d    = (state_d == state_q && (state_q == READ_LO || state_q == READ_HI))
               ? cnt_q + RCW'(1) : '0;
    chan_d   = chan_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;

    if (state_q == WAIT_BUSY && busy_fall_q) chan_d = '0;
    if (hi_done && chan_q != LAST_CH)        chan_d = chan_q + CHW'(1);
    if (lo_done)                             shadow_d[chan_q] = bus.ad_db;

    if (bus.frame_ack) rdy_d = 1'b0;
    if (bus.err_clr)   ovr_d = 1'b0;
    if (state_q == DONE) begin
      frame_d = shadow_q;
      rdy_d   = 1'b1;
      if (rdy_q && !bus.frame_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      cnt_q    <= '0;
      chan_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      rdy_q    <= rdy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.ad_cs_bar = cs_q;
  assign bus.ad_rd_bar = rd_q;
  assign bus.ch_data   = frame_q;
  assign bus.frame_rdy = rdy_q;
  assign bus.overrun   = ovr_q;

endmodule
